// File: rtl/s_machine_core.sv
// s_machine_core: multi-cycle S-Machine interpreter with a DATA_W-wide A/B
// register pair, a req/ack data-memory port and a terminal HALT state.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                permits issue of the instruction on inst
//   inst[15:0]            current instruction from ROM (stable while busy)
//   PC[PC_W-1:0]          address of the current instruction
//   mem_req/mem_we        memory request (held until ack), 1 = store
//   mem_addr[8:0]         inst[8:0] of the memory instruction
//   mem_wdata[DATA_W-1:0] store data
//   mem_rdata, mem_ack    load data, valid in the single-cycle ack
//   busy, halted          busy in MEM_WAIT/HALT, halted in HALT
//   flags[2:0]            {Z,N,C}
module s_machine_core #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [15:0]       inst,
    output logic [PC_W-1:0]   PC,
    output logic              mem_req,
    output logic              mem_we,
    output logic [8:0]        mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              halted,
    output logic [2:0]        flags
);

    localparam logic [1:0] S_EXEC = 2'd0, S_MEM = 2'd1, S_HALT = 2'd2;

    localparam logic [3:0] OP_LD  = 4'h0, OP_ST  = 4'h1, OP_INC = 4'h2, OP_BR   = 4'h3,
                           OP_ADD = 4'h4, OP_SUB = 4'h5, OP_OR  = 4'h6, OP_AND  = 4'h7,
                           OP_XOR = 4'h8, OP_SHR = 4'h9, OP_MOV = 4'hA, OP_EXCH = 4'hB,
                           OP_CMP = 4'hC, OP_SET = 4'hD, OP_CLR = 4'hE, OP_HALT = 4'hF;

    logic [1:0]        state_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [2:0]        flags_q;
    logic [PC_W-1:0]   pc_q;
    logic              ld_b_q;     // load destination remembered across wait states

    logic [3:0]        op;
    logic              sel_b;
    logic [2:0]        mask;
    logic [DATA_W-1:0] imm, ld_val, reg_sel;
    logic [DATA_W:0]   inc_sum, add_sum, sub_dif;
    logic [PC_W-1:0]   pc_inc;
    logic              br_taken;

    assign op      = inst[15:12];
    assign sel_b   = inst[11];
    assign mask    = inst[10:8];
    assign imm     = DATA_W'(inst[7:0]);
    assign ld_val  = inst[9] ? (imm << (DATA_W - 8)) : imm;
    assign reg_sel = sel_b ? b_q : a_q;
    // One extra bit on each sum: the MSB is carry for add, borrow for subtract.
    assign inc_sum = {1'b0, reg_sel} + {1'b0, imm};
    assign add_sum = {1'b0, a_q} + {1'b0, b_q};
    assign sub_dif = {1'b0, a_q} - {1'b0, b_q};
    assign pc_inc  = pc_q + PC_W'(1);
    // Inverted sense tests for any masked flag clear; an empty mask never fires.
    assign br_taken = sel_b ? |(mask & ~flags_q) : (|(mask & flags_q) || mask == 3'b000);

    function automatic logic [1:0] zn(input logic [DATA_W-1:0] r);
        return {r == '0, r[DATA_W-1]};
    endfunction

    logic [DATA_W-1:0] a_n, b_n;
    logic [2:0]        f_n;
    logic [PC_W-1:0]   pc_n;
    logic [1:0]        st_n;
    logic              mem_go;

    always_comb begin
        a_n    = a_q;
        b_n    = b_q;
        f_n    = flags_q;
        pc_n   = pc_inc;
        st_n   = S_EXEC;
        mem_go = 1'b0;
        case (op)
            OP_LD: begin
                if (inst[10]) begin
                    if (sel_b) b_n = ld_val;
                    else       a_n = ld_val;
                end else begin
                    mem_go = 1'b1;
                    pc_n   = pc_q;
                    st_n   = S_MEM;
                end
            end
            OP_ST: begin
                mem_go = 1'b1;
                pc_n   = pc_q;
                st_n   = S_MEM;
            end
            OP_INC: begin
                if (sel_b) b_n = inc_sum[DATA_W-1:0];
                else       a_n = inc_sum[DATA_W-1:0];
                f_n = {zn(inc_sum[DATA_W-1:0]), inc_sum[DATA_W]};
            end
            OP_BR:   pc_n = br_taken ? PC_W'(inst[7:0]) : pc_inc;
            OP_ADD: begin
                a_n = add_sum[DATA_W-1:0];
                f_n = {zn(add_sum[DATA_W-1:0]), add_sum[DATA_W]};
            end
            OP_SUB: begin
                a_n = sub_dif[DATA_W-1:0];
                f_n = {zn(sub_dif[DATA_W-1:0]), sub_dif[DATA_W]};
            end
            OP_CMP:  f_n = {zn(sub_dif[DATA_W-1:0]), sub_dif[DATA_W]};
            OP_OR: begin
                a_n = a_q | b_q;
                f_n = {zn(a_q | b_q), 1'b0};
            end
            OP_AND: begin
                a_n = a_q & b_q;
                f_n = {zn(a_q & b_q), 1'b0};
            end
            OP_XOR: begin
                a_n = a_q ^ b_q;
                f_n = {zn(a_q ^ b_q), 1'b0};
            end
            OP_SHR: begin
                a_n = a_q >> 1;
                f_n = {zn(a_q >> 1), a_q[0]};
            end
            OP_MOV:  b_n = a_q;
            OP_EXCH: begin
                a_n = b_q;
                b_n = a_q;
            end
            OP_SET:  f_n = flags_q | mask;
            OP_CLR:  f_n = flags_q & ~mask;
            OP_HALT: begin
                pc_n = pc_q;
                st_n = S_HALT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_EXEC;
            a_q       <= '0;
            b_q       <= '0;
            flags_q   <= '0;
            pc_q      <= '0;
            ld_b_q    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state_q)
                S_EXEC: if (enable) begin
                    a_q     <= a_n;
                    b_q     <= b_n;
                    flags_q <= f_n;
                    pc_q    <= pc_n;
                    state_q <= st_n;
                    if (mem_go) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (op == OP_ST);
                        mem_addr  <= inst[8:0];
                        mem_wdata <= reg_sel;
                        ld_b_q    <= sel_b;
                    end
                end
                S_MEM: if (mem_ack) begin
                    mem_req <= 1'b0;
                    pc_q    <= pc_inc;
                    state_q <= S_EXEC;
                    if (!mem_we) begin
                        if (ld_b_q) b_q <= mem_rdata;
                        else        a_q <= mem_rdata;
                    end
                end
                default: ;  // HALT: only reset leaves
            endcase
        end
    end

    assign PC     = pc_q;
    assign flags  = flags_q;
    assign busy   = (state_q != S_EXEC);
    assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_s_machine_core.sv
// Directed bench for s_machine_core (DATA_W=16, PC_W=8). Register contents are
// observed by storing them and checking mem_wdata.
module tb_s_machine_core;
    localparam int DW = 16;
    localparam int PW = 8;

    logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, mem_ack = 1'b0;
    logic [15:0]   inst = 16'h0;
    logic [DW-1:0] mem_rdata = '0;
    logic [PW-1:0] PC;
    logic          mem_req, mem_we, busy, halted;
    logic [8:0]    mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    flags;

    int total = 0, passed = 0, fails = 0;
    int epc = 0;

    s_machine_core #(.DATA_W(DW), .PC_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .inst(inst), .PC(PC),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .halted(halted), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exec(input logic [15:0] i);
        inst   = i;
        enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    // Single-cycle instruction: PC must advance by one.
    task automatic nonmem(input logic [15:0] i, input string tag);
        exec(i);
        epc = (epc + 1) & 8'hFF;
        chk(tag, 32'(PC), 32'(epc));
    endtask

    // Store register (b selects B) to addr, check the request, ack immediately.
    task automatic st_chk(input logic b, input logic [8:0] addr, input logic [15:0] exp,
                          input string tag);
        exec({4'h1, b, 2'b00, addr});
        chk({tag, "_req"},   32'(mem_req), 32'd1);
        chk({tag, "_we"},    32'(mem_we), 32'd1);
        chk({tag, "_addr"},  32'(mem_addr), 32'(addr));
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'(exp));
        chk({tag, "_pc"},    32'(PC), 32'(epc));
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        epc = (epc + 1) & 8'hFF;
        chk({tag, "_done"},  32'(mem_req), 32'd0);
        chk({tag, "_pc2"},   32'(PC), 32'(epc));
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_pc", 32'(PC), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        #10 rst_n = 1'b1;

        // LD A #0x34 hi
        nonmem(16'h0634, "ld_hi_pc");
        chk("ld_hi_pc1", 32'(PC), 32'd1);
        st_chk(1'b0, 9'h000, 16'h3400, "ld_hi");

        // A=0xFFFF via LD hi + INC, B=1, then ADD and SUB
        nonmem(16'h06FF, "ldff_pc");
        nonmem(16'h20FF, "inc_pc");
        chk("inc_flags", 32'(flags), 32'b010);
        nonmem(16'h0C01, "ldb_pc");
        nonmem(16'h4000, "add_pc");
        chk("add_flags", 32'(flags), 32'b101);
        st_chk(1'b0, 9'h001, 16'h0000, "add_a");
        nonmem(16'h5000, "sub_pc");
        chk("sub_flags", 32'(flags), 32'b011);
        st_chk(1'b0, 9'h002, 16'hFFFF, "sub_a");

        // Ack outside MEM_WAIT is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("stray_ack_pc", 32'(PC), 32'(epc));
        chk("stray_ack_busy", 32'(busy), 32'd0);

        // ST B to 0x1A2 with four wait cycles before ack
        exec(16'h19A2);
        for (int c = 0; c < 5; c++) begin
            chk("stw_req", 32'(mem_req), 32'd1);
            chk("stw_we", 32'(mem_we), 32'd1);
            chk("stw_addr", 32'(mem_addr), 32'h1A2);
            chk("stw_busy", 32'(busy), 32'd1);
            chk("stw_pc", 32'(PC), 32'(epc));
            if (c < 4) step();
        end
        chk("stw_wdata", 32'(mem_wdata), 32'h0001);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        epc = (epc + 1) & 8'hFF;
        chk("stw_done_req", 32'(mem_req), 32'd0);
        chk("stw_done_pc", 32'(PC), 32'(epc));

        // LD A from memory, ack in 2nd wait cycle, enable toggling
        exec(16'h0005);
        chk("ldm_we", 32'(mem_we), 32'd0);
        chk("ldm_addr", 32'(mem_addr), 32'h005);
        enable = 1'b1;
        step();
        chk("ldm_wait_pc", 32'(PC), 32'(epc));
        enable    = 1'b0;
        #3 enable = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        enable  = 1'b0;
        mem_ack = 1'b0;
        epc = (epc + 1) & 8'hFF;
        chk("ldm_pc", 32'(PC), 32'(epc));
        chk("ldm_busy", 32'(busy), 32'd0);
        step();
        chk("ldm_pc_hold", 32'(PC), 32'(epc));
        st_chk(1'b0, 9'h003, 16'hBEEF, "ldm_a");

        // Branches with Z=1 only
        nonmem(16'hE700, "clr_pc");
        chk("clr_flags", 32'(flags), 32'b000);
        nonmem(16'hD400, "set_pc");
        chk("set_flags", 32'(flags), 32'b100);
        exec(16'h3410); epc = 8'h10;
        chk("bz_pc", 32'(PC), 32'h10);
        nonmem(16'h3C10, "bnz_pc");
        exec(16'h3010); epc = 8'h10;
        chk("b_always_pc", 32'(PC), 32'h10);
        nonmem(16'h3810, "b_never_pc");
        exec(16'h30FF); epc = 8'hFF;
        chk("b_ff_pc", 32'(PC), 32'hFF);
        nonmem(16'hA000, "mov_wrap_pc");
        chk("wrap_pc0", 32'(PC), 32'h00);
        st_chk(1'b1, 9'h004, 16'hBEEF, "mov_b");

        // XOR clears C; CMP sets borrow without writing A
        nonmem(16'hD100, "setc_pc");
        chk("setc_flags", 32'(flags), 32'b101);
        nonmem(16'h8000, "xor_pc");
        chk("xor_flags", 32'(flags), 32'b100);
        nonmem(16'hC000, "cmp_pc");
        chk("cmp_flags", 32'(flags), 32'b001);
        st_chk(1'b0, 9'h005, 16'h0000, "cmp_a");

        // HALT holds PC, ignores enable
        exec(16'hF000);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_busy", 32'(busy), 32'd1);
        chk("halt_pc", 32'(PC), 32'(epc));
        inst = 16'h0000; enable = 1'b1;
        step(); step();
        enable = 1'b0;
        chk("halt_hold_pc", 32'(PC), 32'(epc));
        chk("halt_hold", 32'(halted), 32'd1);

        // Asynchronous reset mid-cycle
        rst_n = 1'b0;
        #1;
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_pc", 32'(PC), 32'd0);
        chk("arst_flags", 32'(flags), 32'd0);
        #1 rst_n = 1'b1;
        epc = 0;

        // Reset during a pending ST, then a late ack
        exec(16'h10AA);
        chk("pend_req", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst2_req", 32'(mem_req), 32'd0);
        chk("arst2_busy", 32'(busy), 32'd0);
        chk("arst2_addr", 32'(mem_addr), 32'd0);
        #1 rst_n = 1'b1;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("late_ack_pc", 32'(PC), 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
